multicycle_control: RTL
=======================

# multicycle_control

Control unit for the multicycle CPU: a Moore FSM that sequences fetch, decode, execute, memory and write-back, and drives every select and enable of the multicycle datapath. Inputs are the opcode and funct fields from the instruction register, plus a data-memory ready handshake. Outputs connect one-to-one to the datapath control inputs. It also keeps a retired-instruction counter and a halt flag for the bench.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears FSM, counter, halt flag
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  data memory access complete this cycle
- pc_write  out  1  unconditional PC write
- branch  out  1  conditional PC write; datapath writes PC when branch & zero
- ir_write  out  1  load instruction register
- instr_mem_enable  out  1  instruction memory read
- data_mem_enable  out  1  data memory access request
- data_mem_write  out  1  access is a write (valid with data_mem_enable)
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- reg_file_enable  out  1  register file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data
- halted  out  1  FSM in HALT
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- R-type funct values: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- Unlisted opcode or funct goes to HALT.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: instr_mem_enable, ir_write, pc_write; a=0, b=01, add, pc_source=00. Goes to DECODE.
- DECODE: a=0, b=11, add (branch target into ALUOut). Dispatches on opcode:
  - lw/sw to MEM_ADDR
  - R to R_EXEC
  - beq to BRANCH
  - addi to ADDI_EXEC
  - j to JUMP
  - otherwise HALT
- MEM_ADDR: a=1, b=10, add. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: data_mem_enable=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_file_enable, mem_to_reg=1, reg_dst=0. Retires, goes to FETCH.
- MEM_WRITE: data_mem_enable=1, data_mem_write=1. Holds until mem_ready, then retires and goes to FETCH.
- R_EXEC: a=1, b=00, alu_control from funct. Goes to R_WB.
- R_WB: reg_file_enable, reg_dst=1, mem_to_reg=0. Retires, goes to FETCH.
- BRANCH: a=1, b=00, sub, branch=1, pc_source=01. Retires, goes to FETCH.
- ADDI_EXEC: a=1, b=10, add. Goes to ADDI_WB.
- ADDI_WB: reg_file_enable, reg_dst=0, mem_to_reg=0. Retires, goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Retires, goes to FETCH.
- HALT: all outputs 0, halted=1. Absorbing until reset.
- Retire: instr_count += 1 on the edge that leaves the retiring state. It wraps from all-ones to 0.

## Timing
- All outputs are Moore and decoded from the registered state only; no input-to-output combinational path.
- Reset value of every output is 0, including halted and instr_count; the state is IDLE.
- First FETCH is on the second rising edge after reset deasserts.
- Latency in cycles, FETCH to next FETCH, with mem_ready already high:
  - beq 3, j 3
  - R 4, addi 4, sw 4
  - lw 5
- Each cycle mem_ready is low adds one cycle.
- mem_ready is sampled only in MEM_READ and MEM_WRITE and ignored elsewhere.
- data_mem_enable stays high continuously until the accepting edge.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. The partial instruction is not counted.

## Configuration
- MC_CTRL_JUMP_EN defined: opcode 0x02 goes to JUMP, and pc_source=10 is reachable.
- Not defined: the JUMP state is absent, 0x02 goes to HALT, and pc_source is never 10.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode and funct constants
  - alu_control codes
  - alu_src_b and pc_source select codes
- Sub-module alu_decoder: combinational, funct to {alu_control, illegal}. Used in R_EXEC and in the DECODE dispatch check.

## Test plan
- Reset release, opcode=0x00, funct=0x20, mem_ready=1:
  - IDLE, FETCH, DECODE, R_EXEC (alu_control=010), R_WB (reg_dst=1, reg_file_enable=1)
  - instr_count 0 to 1 after 5 cycles
- lw (0x23) with mem_ready low for 2 cycles in MEM_READ:
  - data_mem_enable high for 3 cycles, data_mem_write=0
  - MEM_WB with mem_to_reg=1
  - 7 cycles FETCH to FETCH
- beq (0x04): BRANCH cycle shows branch=1, pc_source=01, alu_control=110, pc_write=0; 3-cycle instruction.
- Opcode 0x3F, then R-type with funct 0x00: each reaches HALT (halted=1, all controls 0) and stays there for 20 cycles; instr_count is unchanged.
- j (0x02):
  - with MC_CTRL_JUMP_EN: JUMP cycle shows pc_write=1, pc_source=10
  - without it: HALT after DECODE
- Reset pulsed low during MEM_WRITE: all outputs 0 asynchronously, instr_count=0, restart via IDLE. Then preload instr_count to all-ones through retires with CNT_W=4 and check it wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: states, opcode/funct constants and datapath select codes for multicycle_control.
// The JUMP state and its encodings exist only when MC_CTRL_JUMP_EN is defined.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        s_idle,
        s_fetch,
        s_decode,
        s_mem_addr,
        s_mem_read,
        s_mem_wb,
        s_mem_write,
        s_r_exec,
        s_r_wb,
        s_branch,
        s_addi_exec,
        s_addi_wb,
`ifdef MC_CTRL_JUMP_EN
        s_jump,
`endif
        s_halt
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [1:0] PCS_JUMP = 2'b10;
`endif
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields, memory handshake and datapath controls.
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write;
    logic             branch;
    logic             ir_write;
    logic             instr_mem_enable;
    logic             data_mem_enable;
    logic             data_mem_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic [1:0]       pc_source;
    logic             reg_file_enable;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, branch, ir_write, instr_mem_enable, data_mem_enable, data_mem_write,
               alu_src_a, alu_src_b, alu_control, pc_source, reg_file_enable, reg_dst,
               mem_to_reg, halted, instr_count
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, branch, ir_write, instr_mem_enable, data_mem_enable, data_mem_write,
               alu_src_a, alu_src_b, alu_control, pc_source, reg_file_enable, reg_dst,
               mem_to_reg, halted, instr_count
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps an R-type funct field to an ALU operation and flags unsupported values.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);
    always_comb begin
        alu_control = funct == FN_ADD ? ALU_ADD :
                      funct == FN_SUB ? ALU_SUB :
                      funct == FN_OR  ? ALU_OR  :
                      funct == FN_SLT ? ALU_SLT : ALU_AND;
        illegal     = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle datapath, with retired-instruction counter.
// Optional feature: define MC_CTRL_JUMP_EN to support the j instruction (opcode 0x02).
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);
    state_t           state, state_nx;
    logic [2:0]       r_alu, dec_alu;
    logic             dec_ill, retire;
    logic [CNT_W-1:0] count;

    alu_decoder u_alu_decoder (
        .funct       (bus.funct),
        .alu_control (dec_alu),
        .illegal     (dec_ill)
    );

    // The R-type ALU op is latched at DECODE so R_EXEC outputs depend on state only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= s_idle;
            r_alu <= ALU_AND;
            count <= '0;
        end else begin
            state <= state_nx;
            if (state == s_decode) r_alu <= dec_alu;
            if (retire) count <= count + CNT_W'(1);
        end
    end

    assign bus.halted      = state == s_halt;
    assign bus.instr_count = count;

    always_comb begin
        state_nx             = state;
        retire               = 1'b0;
        bus.pc_write         = 1'b0;
        bus.branch           = 1'b0;
        bus.ir_write         = 1'b0;
        bus.instr_mem_enable = 1'b0;
        bus.data_mem_enable  = 1'b0;
        bus.data_mem_write   = 1'b0;
        bus.alu_src_a        = 1'b0;
        bus.alu_src_b        = SRCB_B;
        bus.alu_control      = ALU_AND;
        bus.pc_source        = PCS_ALU;
        bus.reg_file_enable  = 1'b0;
        bus.reg_dst          = 1'b0;
        bus.mem_to_reg       = 1'b0;
        case (state)
            s_idle: state_nx = s_fetch;
            s_fetch: begin
                bus.instr_mem_enable = 1'b1;
                bus.ir_write         = 1'b1;
                bus.pc_write         = 1'b1;
                bus.alu_src_b        = SRCB_4;
                bus.alu_control      = ALU_ADD;
                state_nx             = s_decode;
            end
            s_decode: begin
                bus.alu_src_b   = SRCB_IMM_SH;
                bus.alu_control = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_nx = s_mem_addr;
                    OP_R:         state_nx = dec_ill ? s_halt : s_r_exec;
                    OP_BEQ:       state_nx = s_branch;
                    OP_ADDI:      state_nx = s_addi_exec;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         state_nx = s_jump;
`endif
                    default:      state_nx = s_halt;
                endcase
            end
            s_mem_addr: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_control = ALU_ADD;
                state_nx        = bus.opcode == OP_SW ? s_mem_write : s_mem_read;
            end
            s_mem_read: begin
                bus.data_mem_enable = 1'b1;
                state_nx            = bus.mem_ready ? s_mem_wb : s_mem_read;
            end
            s_mem_wb: begin
                bus.reg_file_enable = 1'b1;
                bus.mem_to_reg      = 1'b1;
                retire              = 1'b1;
                state_nx            = s_fetch;
            end
            s_mem_write: begin
                bus.data_mem_enable = 1'b1;
                bus.data_mem_write  = 1'b1;
                retire              = bus.mem_ready;
                state_nx            = bus.mem_ready ? s_fetch : s_mem_write;
            end
            s_r_exec: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = r_alu;
                state_nx        = s_r_wb;
            end
            s_r_wb: begin
                bus.reg_file_enable = 1'b1;
                bus.reg_dst         = 1'b1;
                retire              = 1'b1;
                state_nx            = s_fetch;
            end
            s_branch: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                bus.branch      = 1'b1;
                bus.pc_source   = PCS_ALUOUT;
                retire          = 1'b1;
                state_nx        = s_fetch;
            end
            s_addi_exec: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_control = ALU_ADD;
                state_nx        = s_addi_wb;
            end
            s_addi_wb: begin
                bus.reg_file_enable = 1'b1;
                retire              = 1'b1;
                state_nx            = s_fetch;
            end
`ifdef MC_CTRL_JUMP_EN
            s_jump: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_JUMP;
                retire        = 1'b1;
                state_nx      = s_fetch;
            end
`endif
            s_halt: state_nx = s_halt;
            default: state_nx = s_idle;
        endcase
    end
endmodule
